// File: rtl/mdu_iter_if.sv
// rtl/mdu_iter_if.sv - start/busy/done and HI/LO bus between EX stage and the multiply/divide unit
//
// Ports (master = pipeline side, slave = mdu_iter):
//   start   op valid this cycle, sampled only while busy=0
//   op      operation code (MULT/MULTU/DIV/DIVU/MTHI/MTLO, optional MADD family)
//   rs, rt  operands A and B
//   cancel  abort an in-flight op
//   busy    iterative op in progress
//   done    one-cycle pulse when an iterative op writes HI/LO
//   hi, lo  architectural HI/LO registers
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs, rt, cancel,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs, rt, cancel,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative shift-add multiply / restoring divide unit holding HI/LO
//
// One product or quotient bit is produced per cycle, so an accepted MULT/DIV
// family op keeps busy high for exactly WIDTH cycles before HI/LO are written.
// MTHI/MTLO write in a single cycle while idle.
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   reset  synchronous, active-high
//   bus    mdu_iter_if slave modport (start/op/rs/rt/cancel in, busy/done/hi/lo out)
//
// Optional feature: define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU
// (ops 8-11), which accumulate the product into {hi,lo}. Without it those
// codes are NOPs and no accumulate adder exists.
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic      clk,
    input logic      reset,
    mdu_iter_if.slave bus
);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd6;
    localparam logic [3:0] OP_MTLO  = 4'd7;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd8;
    localparam logic [3:0] OP_MADDU = 4'd9;
    localparam logic [3:0] OP_MSUB  = 4'd10;
    localparam logic [3:0] OP_MSUBU = 4'd11;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    // Shared work register. MUL: upper half = partial product, lower half =
    // multiplier shifting out. DIV: upper half = remainder, lower half =
    // dividend shifting out / quotient shifting in.
    logic [2*WIDTH-1:0]   p;
    logic [WIDTH-1:0]     b_reg;      // multiplicand or divisor magnitude
    logic                 neg_q;      // negate product / quotient
    logic                 neg_r;      // negate remainder
    logic                 div_zero;
    logic                 busy_r;
    logic                 done_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;
`ifdef MDU_MADD_EN
    logic                 acc_r;
    logic                 acc_sub_r;
`endif

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

    // Op decode
    logic dec_mul, dec_div, dec_signed;
`ifdef MDU_MADD_EN
    logic dec_acc, dec_sub;
`endif

    always_comb begin
        dec_mul    = 1'b0;
        dec_div    = 1'b0;
        dec_signed = 1'b0;
`ifdef MDU_MADD_EN
        dec_acc    = 1'b0;
        dec_sub    = 1'b0;
`endif
        case (bus.op)
            OP_MULT:  begin dec_mul = 1'b1; dec_signed = 1'b1; end
            OP_MULTU: dec_mul = 1'b1;
            OP_DIV:   begin dec_div = 1'b1; dec_signed = 1'b1; end
            OP_DIVU:  dec_div = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD:  begin dec_mul = 1'b1; dec_signed = 1'b1; dec_acc = 1'b1; end
            OP_MADDU: begin dec_mul = 1'b1; dec_acc = 1'b1; end
            OP_MSUB:  begin dec_mul = 1'b1; dec_signed = 1'b1; dec_acc = 1'b1; dec_sub = 1'b1; end
            OP_MSUBU: begin dec_mul = 1'b1; dec_acc = 1'b1; dec_sub = 1'b1; end
`endif
            default: ;
        endcase
    end

    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_mag = (dec_signed && bus.rs[WIDTH-1]) ? -bus.rs : bus.rs;
    assign b_mag = (dec_signed && bus.rt[WIDTH-1]) ? -bus.rt : bus.rt;

    // Multiply step: conditionally add multiplicand into the upper half,
    // then shift the whole register right, carry entering at the top.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    assign mul_sum  = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, b_reg} : '0);
    assign mul_next = {mul_sum, p[WIDTH-1:1]};

    // Restoring divide step: the shifted partial remainder is WIDTH+1 bits;
    // when it is >= divisor the difference always fits back into WIDTH bits.
    logic                 div_ok;
    logic [WIDTH-1:0]     div_sub;
    logic [2*WIDTH-1:0]   div_next;
    assign div_ok   = p[2*WIDTH-1:WIDTH-1] >= {1'b0, b_reg};
    assign div_sub  = p[2*WIDTH-2:WIDTH-1] - b_reg;
    assign div_next = div_ok ? {div_sub, p[WIDTH-2:0], 1'b1}
                             : {p[2*WIDTH-2:0], 1'b0};

    logic [2*WIDTH-1:0]   p_next;
    assign p_next = (state == S_DIV) ? div_next : mul_next;

    // Sign-corrected results, taken from the final step's value
    logic [2*WIDTH-1:0]   prod_res;
    logic [WIDTH-1:0]     q_res, r_res;
    assign prod_res = neg_q ? -p_next : p_next;
    // Divide by zero: quotient all ones; the remainder path already yields
    // rs because a zero divisor never fails the trial subtraction.
    assign q_res    = div_zero ? '1 : (neg_q ? -p_next[WIDTH-1:0] : p_next[WIDTH-1:0]);
    assign r_res    = neg_r ? -p_next[2*WIDTH-1:WIDTH] : p_next[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            p         <= '0;
            b_reg     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            div_zero  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            hi_r      <= '0;
            lo_r      <= '0;
`ifdef MDU_MADD_EN
            acc_r     <= 1'b0;
            acc_sub_r <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start && !bus.cancel) begin
                        if (dec_mul || dec_div) begin
                            state    <= dec_mul ? S_MUL : S_DIV;
                            cnt      <= CNT_W'(WIDTH);
                            busy_r   <= 1'b1;
                            b_reg    <= dec_mul ? a_mag : b_mag;
                            p        <= {{WIDTH{1'b0}}, (dec_mul ? b_mag : a_mag)};
                            neg_q    <= dec_signed && (bus.rs[WIDTH-1] ^ bus.rt[WIDTH-1]);
                            neg_r    <= dec_signed && bus.rs[WIDTH-1];
                            div_zero <= dec_div && (bus.rt == '0);
`ifdef MDU_MADD_EN
                            acc_r     <= dec_acc;
                            acc_sub_r <= dec_sub;
`endif
                        end else if (bus.op == OP_MTHI) begin
                            hi_r <= bus.rs;
                        end else if (bus.op == OP_MTLO) begin
                            lo_r <= bus.rs;
                        end
                    end
                end
                default: begin
                    if (bus.cancel) begin
                        state  <= S_IDLE;
                        busy_r <= 1'b0;
                    end else begin
                        p   <= p_next;
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            state  <= S_IDLE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            if (state == S_MUL) begin
`ifdef MDU_MADD_EN
                                if (acc_r) begin
                                    if (acc_sub_r)
                                        {hi_r, lo_r} <= {hi_r, lo_r} - prod_res;
                                    else
                                        {hi_r, lo_r} <= {hi_r, lo_r} + prod_res;
                                end else begin
                                    {hi_r, lo_r} <= prod_res;
                                end
`else
                                {hi_r, lo_r} <= prod_res;
`endif
                            end else begin
                                hi_r <= r_res;
                                lo_r <= q_res;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - self-checking bench for mdu_iter with an expected-result scoreboard
module tb_mdu_iter;
    localparam int W = 32;
    localparam int NONE = 1000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_iter_if #(.WIDTH(W)) bus ();

    mdu_iter #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, pr;
        int ia, ib, iq, ir;
        logic [31:0] q32, r32;
        case (o)
            4'd0: begin sa = $signed(a); sb = $signed(b); pr = sa * sb; return 64'(pr); end
            4'd1: return {32'd0, a} * {32'd0, b};
            4'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                ia = $signed(a); ib = $signed(b);
                iq = ia / ib; ir = ia % ib;
                q32 = iq; r32 = ir;
                return {r32, q32};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Drive an op for one cycle at the current negedge and queue its result.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] e);
        bus.start = 1'b1; bus.op = o; bus.rs = a; bus.rt = b;
        exp_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0; bus.op = 4'd15;
    endtask

    // Follow an accepted op to completion (or cancel) and score it.
    task automatic finish_op(input string tag, input int cancel_at, input int inject_at);
        int n;
        bit seen;
        logic [63:0] e;
        logic [63:0] pre;
        n = 0; seen = 1'b0;
        pre = {bus.hi, bus.lo};
        for (int i = 0; i < 100; i++) begin
            if (bus.done) begin seen = 1'b1; break; end
            if (bus.busy) n++;
            bus.cancel = (i == cancel_at);
            if (i == inject_at) begin
                bus.start = 1'b1; bus.op = 4'd7; bus.rs = 32'hDEAD_BEEF;
            end else if (i == inject_at + 1) begin
                bus.start = 1'b1; bus.op = 4'd1; bus.rs = 32'd5; bus.rt = 32'd5;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            if (i == cancel_at) break;
        end
        bus.start = 1'b0; bus.cancel = 1'b0; bus.op = 4'd15;
        e = exp_q.pop_front();
        if (cancel_at != NONE) begin
            check({tag, "_busy_after_cancel"}, 64'(bus.busy), 64'd0);
            check({tag, "_done_after_cancel"}, 64'(bus.done), 64'd0);
            check({tag, "_hilo_kept"}, {bus.hi, bus.lo}, pre);
        end else begin
            check({tag, "_done_seen"}, 64'(seen), 64'd1);
            check({tag, "_busy_cycles"}, 64'(n), 64'(W));
            check({tag, "_hi"}, 64'(bus.hi), 64'(e[63:32]));
            check({tag, "_lo"}, 64'(bus.lo), 64'(e[31:0]));
        end
    endtask

    initial begin
        logic [3:0]  ro;
        logic [31:0] ra, rb;

        bus.start = 1'b0; bus.cancel = 1'b0; bus.op = 4'd15;
        bus.rs = '0; bus.rt = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_hi", 64'(bus.hi), 64'd0);
        check("reset_lo", 64'(bus.lo), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(4'd0, 32'hFFFF_FFFF, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFE});
        finish_op("mult", NONE, NONE);
        @(negedge clk);
        check("mult_done_one_cycle", 64'(bus.done), 64'd0);

        issue(4'd1, 32'hFFFF_FFFF, 32'd2, {32'h0000_0001, 32'hFFFF_FFFE});
        finish_op("multu", NONE, NONE);

        issue(4'd2, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        finish_op("div_neg", NONE, NONE);

        issue(4'd3, 32'd7, 32'd0, {32'd7, 32'hFFFF_FFFF});
        finish_op("divu_by0", NONE, NONE);

        issue(4'd2, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
        finish_op("div_by0", NONE, NONE);

        bus.start = 1'b1; bus.op = 4'd6; bus.rs = 32'h0000_1234;
        @(negedge clk);
        bus.start = 1'b0;
        check("mthi_hi", 64'(bus.hi), 64'h1234);
        check("mthi_busy", 64'(bus.busy), 64'd0);

        issue(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
        finish_op("div_cancel", 9, NONE);
        repeat (40) @(negedge clk);
        check("cancel_no_late_write", {bus.hi, bus.lo}, {32'h0000_1234, 32'hFFFF_FFFF});

        issue(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
        finish_op("div_ovf", NONE, NONE);

        issue(4'd1, 32'd3, 32'd3, {32'd0, 32'd9});
        finish_op("cancel_on_last", 31, NONE);
        @(negedge clk);
        check("cancel_on_last_late", {bus.hi, bus.lo}, {32'd0, 32'h8000_0000});

        issue(4'd3, 32'd9, 32'd2, {32'd1, 32'd4});
        finish_op("divu_inject", NONE, 5);
        issue(4'd1, 32'd3, 32'd4, {32'd0, 32'd12});
        finish_op("multu_b2b", NONE, NONE);

        bus.start = 1'b1; bus.cancel = 1'b1; bus.op = 4'd7; bus.rs = 32'hABCD;
        @(negedge clk);
        check("mtlo_cancel_lo", 64'(bus.lo), 64'd12);
        bus.op = 4'd2; bus.rs = 32'd8; bus.rt = 32'd2;
        @(negedge clk);
        check("div_cancel_at_start_busy", 64'(bus.busy), 64'd0);
        bus.start = 1'b0; bus.cancel = 1'b0;

        bus.start = 1'b1; bus.op = 4'd5; bus.rs = 32'h77;
        @(negedge clk);
        bus.start = 1'b0;
        check("nop_busy", 64'(bus.busy), 64'd0);
        check("nop_hilo", {bus.hi, bus.lo}, {32'd0, 32'd12});

`ifdef MDU_MADD_EN
        bus.start = 1'b1; bus.op = 4'd6; bus.rs = 32'd0;
        @(negedge clk);
        bus.op = 4'd7; bus.rs = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        issue(4'd8, 32'd3, 32'd4, {32'd0, 32'h11});
        finish_op("madd", NONE, NONE);
        issue(4'd11, 32'd1, 32'h12, {32'hFFFF_FFFF, 32'hFFFF_FFFF});
        finish_op("msubu", NONE, NONE);
`else
        bus.start = 1'b1; bus.op = 4'd8; bus.rs = 32'd3; bus.rt = 32'd4;
        @(negedge clk);
        bus.start = 1'b0;
        check("madd_off_busy", 64'(bus.busy), 64'd0);
        check("madd_off_hilo", {bus.hi, bus.lo}, {32'd0, 32'd12});
`endif

        for (int k = 0; k < 8; k++) begin
            ro = 4'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (k == 2) rb = 32'd0;
            else if (k % 2 == 1) rb = rb >> $urandom_range(16, 31);
            issue(ro, ra, rb, model(ro, ra, rb));
            finish_op($sformatf("rand%0d_op%0d", k, ro), NONE, NONE);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
Parameterised iterative multiply/divide unit for the EX stage of the pipelined MIPS core. Computes one quotient or product bit per cycle using shift-add multiply and restoring division, rather than modelling latency with a counter. Holds the architectural HI/LO registers and serves MTHI/MTLO. Provides a start/busy/done handshake and a cancel input, so the hazard unit can stall MFHI/MFLO and exception flushes can abort an in-flight operation.

Parameters:
WIDTH, 32, operand and HI/LO width; must be even and at least 4.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  synchronous, active-high
start  input  1  op valid this cycle; sampled only when busy=0
op  input  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 6 MTHI, 7 MTLO, 8 MADD, 9 MADDU, 10 MSUB, 11 MSUBU; all other codes are NOP
rs  input  WIDTH  operand A (dividend, multiplicand, or MTHI/MTLO data)
rt  input  WIDTH  operand B (divisor or multiplier)
cancel  input  1  abort an in-flight op (exception flush)
busy  output  1  iterative op in progress
done  output  1  one-cycle pulse on the edge HI/LO are written by an iterative op
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset: hi=0, lo=0, busy=0, done=0. FSM goes to IDLE; counter and datapath registers cleared. Reset overrides every other input and aborts any op.
- FSM states: IDLE, MUL, DIV.
- IDLE with start=1 and a MULT-family or DIV-family op:
  - latch the operand magnitudes (absolute value for signed ops; raw for unsigned);
  - latch result-sign flags and the op;
  - set counter=WIDTH and busy=1;
  - go to MUL or DIV.
- IDLE with start=1 and MTHI/MTLO: hi (or lo) <= rs on that edge; busy stays 0.
- IDLE with start=1 and a NOP code: no effect.
- start while busy=1: ignored, including MTHI/MTLO. The hazard unit stalls these ops.
- MUL: each cycle add the multiplicand to the 2*WIDTH partial product if the current multiplier bit is 1, shift, and decrement the counter.
- DIV: each cycle shift the remainder, trial-subtract the divisor, set the quotient bit, and restore on a negative result; decrement the counter.
- Latency: busy is high for exactly WIDTH cycles. On the edge where the counter reaches 0:
  - hi/lo written with the sign-corrected result;
  - busy falls to 0;
  - done=1 for one cycle;
  - FSM returns to IDLE.
- A new op may be accepted in the first cycle that busy=0.
- Result placement: product goes to {hi,lo}. Quotient goes to lo, remainder to hi.
- Signed sign correction:
  - product is negated if the operand signs differ;
  - quotient is negated if the operand signs differ;
  - remainder takes the sign of the dividend (truncating division).
- Divide by zero (rt=0, DIV or DIVU): lo = all ones, hi = rs. Still takes WIDTH cycles.
- Signed overflow, most-negative / -1: lo = 1 followed by WIDTH-1 zeros (the most-negative value), hi = 0. No trap.
- cancel=1 while busy:
  - FSM returns to IDLE next edge; busy=0, done=0;
  - hi/lo keep their pre-op values.
- cancel=1 on the same edge as start in IDLE: the op is not accepted, and MTHI/MTLO does not write.
- cancel on the completion edge: cancel wins, and hi/lo are not written.
- cancel in IDLE without start: no effect.
- hi/lo outputs are registered and change only on write edges; no forwarding of partial results.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: ops 8–11 are accepted into the MUL state with WIDTH-cycle latency. At completion, {hi,lo} <= {hi,lo} ± product, using a 2*WIDTH add/subtract that wraps modulo 2^(2*WIDTH). MADD/MSUB use the signed product; MADDU/MSUBU use the unsigned product.
- Undefined: codes 8–11 decode as NOP, and the accumulate adder is not synthesised.

Test Plan:
- MULT rs=0xFFFFFFFF, rt=0x00000002 -> busy high for 32 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulses once.
- MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7, rt=0 -> lo=0xFFFFFFFF, hi=0x00000007.
- MTHI 0x1234, then DIV 0x80000000 / 0xFFFFFFFF, with cancel pulsed in cycle 10 -> busy drops next edge and hi stays 0x00001234. A rerun without cancel -> lo=0x80000000, hi=0.
- Back-to-back: MULTU 3*4 accepted the cycle busy falls after a prior DIVU 9/2 -> hi/lo=1/4, then 0/12. A start pulsed mid-op is ignored and MTLO while busy does not write.
- With MDU_MADD_EN: MTHI 0, MTLO 5, MADD 3,4 -> lo=0x11. Then MSUBU 1,0x12 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF.
